conflict_batcher: RTL and testbench
===================================

Name: conflict_batcher

Overview:
Downstream stage of the insertion queue. It consumes one transaction per handshake, as a programID plus read/write dependency bitmaps. Mutually non-conflicting transactions are grouped into a batch that can execute in parallel. A batch closes on a conflict, when full, or on timeout, and is then streamed out entry by entry with tlast marking the final entry, to the execution dispatcher.

Parameters:
MAX_DEPENDENCIES, 256, width of read/write dependency bitmaps
MAX_BATCH_SIZE, 8, max transactions per batch (>=1)
BATCH_TIMEOUT, 64, idle cycles with a non-empty batch before forced close (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_axis_tvalid  in  1  input transaction valid
s_axis_tready  out  1  input ready
s_axis_tdata_owner_programID  in  64  input programID
s_axis_tdata_read_dependencies  in  MAX_DEPENDENCIES  input read set
s_axis_tdata_write_dependencies  in  MAX_DEPENDENCIES  input write set
m_axis_tvalid  out  1  output entry valid
m_axis_tready  in  1  output ready
m_axis_tlast  out  1  last entry of batch
m_axis_tdata_owner_programID  out  64  output programID
m_axis_tdata_read_dependencies  out  MAX_DEPENDENCIES  output read set
m_axis_tdata_write_dependencies  out  MAX_DEPENDENCIES  output write set
batch_count  out  32  batches emitted (stats)
conflict_count  out  32  conflict-triggered closes (stats)

Behaviour:
- Clock: single clk. Reset: asynchronous, active-low rst_n. Reset clears all state and counters. State goes to COLLECT, count=0, carry_valid=0, timer=0, masks B_r/B_w=0. Reset values: m_axis_tvalid=0, m_axis_tlast=0, all m_axis_tdata=0, batch_count=0, conflict_count=0. A reset mid-drain discards the batch and any carry.
- Storage: MAX_BATCH_SIZE entries of {programID, read, write}. Masks B_r and B_w are the OR of all stored read sets and write sets. One carry register holds a conflicting transaction.
- Conflict (combinational on s_axis data): (W & (B_r|B_w)) != 0 OR (R & B_w) != 0. Read-read overlap is not a conflict. An empty batch never conflicts.
- s_axis_tready = (state==COLLECT), combinational from the registered state. An accept is s_axis_tvalid & s_axis_tready.
- COLLECT, accept without conflict: write the entry at index count, OR it into the masks, count+1, timer=0. If the new count == MAX_BATCH_SIZE, go to DRAIN next cycle.
- COLLECT, accept with conflict: store the transaction in carry, carry_valid=1, conflict_count+1, go to DRAIN.
- COLLECT, no accept, count>0: timer+1. When timer reaches BATCH_TIMEOUT-1 in that cycle, go to DRAIN. If count==0, timer holds at 0.
- DRAIN: m_axis_tvalid=1 and m_axis_tdata=entry[rd_idx], registered. m_axis_tlast=1 when rd_idx==count-1. On m_axis_tready, rd_idx+1 and the next entry is presented the following cycle. Output data and valid stay stable while tready=0. Back-to-back beats are allowed.
- Last beat accepted: batch_count+1, rd_idx=0, m_axis_tvalid=0 next cycle, return to COLLECT.
  - If carry_valid: carry becomes entry 0, masks = carry sets, count=1, carry_valid=0, timer=0.
  - Otherwise: masks=0, count=0.
- Latency: first output beat appears 2 cycles after the closing event's accept edge.
- Counters wrap at 2^32.
- MAX_BATCH_SIZE=1: every accept closes the batch immediately and conflict is never raised.

Optional Feature:
Macro BATCHER_STATS_EN.
- Defined: batch_count and conflict_count operate as specified.
- Undefined: both ports are tied to 32'd0, no counter flops are built, and the rest of the behaviour is identical.

Test Plan:
- Three accepts with disjoint sets (W=bit0, bit1, bit2; R=0), then 64 idle cycles with m_axis_tready=1 -> 3 output beats, IDs in order, tlast only on beat 3, batch_count=1.
- A accepted with W=bit5, then B with R=bit5 -> A emitted alone with tlast=1, conflict_count=1; B emitted later as a 1-entry batch after timeout.
- Two entries, both R=bit7 (read-read) -> same batch, 2 beats, conflict_count=0.
- MAX_BATCH_SIZE=8, 8 disjoint accepts back-to-back -> s_axis_tready drops the cycle after the 8th accept, 8 beats out, tready returns after the last beat.
- Drain with m_axis_tready toggling 1,0,0,1 -> data stable during stalls, no beat lost or duplicated.
- rst_n asserted during beat 2 of 4 -> all outputs 0 immediately, carry lost, next input starts a fresh batch.

Source files
------------

// File: rtl/conflict_batcher.sv
`default_nettype none
// ============================================================================
//  Module   : conflict_batcher
//  Purpose  : Groups mutually non-conflicting transactions into batches and
//             streams each closed batch out with tlast on the final entry.
//             Optional statistics counters enabled by BATCHER_STATS_EN.
//  Revision : 1.0  initial release
// ============================================================================
module conflict_batcher #(
   parameter int MAX_DEPENDENCIES = 256,
   parameter int MAX_BATCH_SIZE   = 8,
   parameter int BATCH_TIMEOUT    = 64
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic [63:0]                 s_axis_tdata_owner_programID,
   input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
   input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
   output logic                        m_axis_tvalid,
   input  logic                        m_axis_tready,
   output logic                        m_axis_tlast,
   output logic [63:0]                 m_axis_tdata_owner_programID,
   output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_read_dependencies,
   output logic [MAX_DEPENDENCIES-1:0] m_axis_tdata_write_dependencies,
   output logic [31:0]                 batch_count,
   output logic [31:0]                 conflict_count
);

   localparam int CNT_W = $clog2(MAX_BATCH_SIZE + 1);
   localparam int IDX_W = (MAX_BATCH_SIZE > 1) ? $clog2(MAX_BATCH_SIZE) : 1;
   localparam int TIM_W = (BATCH_TIMEOUT > 1) ? $clog2(BATCH_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] C_FULL         = CNT_W'(MAX_BATCH_SIZE);
   localparam logic [TIM_W-1:0] C_TIMEOUT_LAST = TIM_W'(BATCH_TIMEOUT - 1);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      DRAIN   = 1'b1
   } state_t;

   state_t                      r_state;
   logic [CNT_W-1:0]            r_count;
   logic [IDX_W-1:0]            r_rd_idx;
   logic [TIM_W-1:0]            r_timer;
   logic [MAX_DEPENDENCIES-1:0] r_mask_r;
   logic [MAX_DEPENDENCIES-1:0] r_mask_w;

   logic [63:0]                 r_ent_id [MAX_BATCH_SIZE];
   logic [MAX_DEPENDENCIES-1:0] r_ent_rd [MAX_BATCH_SIZE];
   logic [MAX_DEPENDENCIES-1:0] r_ent_wr [MAX_BATCH_SIZE];

   logic                        r_carry_valid;
   logic [63:0]                 r_carry_id;
   logic [MAX_DEPENDENCIES-1:0] r_carry_rd;
   logic [MAX_DEPENDENCIES-1:0] r_carry_wr;

   logic                        w_accept;
   logic                        w_conflict;
   logic                        w_beat;
   logic                        w_last_beat;
   logic [CNT_W-1:0]            w_count_inc;
   logic [IDX_W-1:0]            w_wr_idx;
   logic [IDX_W-1:0]            w_last_idx;
   logic [IDX_W-1:0]            w_next_idx;

   assign s_axis_tready = (r_state == COLLECT);
   assign w_accept      = s_axis_tvalid && s_axis_tready;

   // Read-read sharing is allowed; an empty batch has all-zero masks.
   assign w_conflict = (r_count != '0) &&
                       ((|(s_axis_tdata_write_dependencies & (r_mask_r | r_mask_w))) ||
                        (|(s_axis_tdata_read_dependencies & r_mask_w)));

   assign w_beat      = (r_state == DRAIN) && m_axis_tvalid && m_axis_tready;
   assign w_last_beat = w_beat && m_axis_tlast;
   assign w_count_inc = r_count + CNT_W'(1);
   assign w_wr_idx    = IDX_W'(r_count);
   assign w_last_idx  = IDX_W'(r_count - CNT_W'(1));
   assign w_next_idx  = r_rd_idx + IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_BATCH_SIZE; i++) begin
            r_ent_id[i] <= '0;
            r_ent_rd[i] <= '0;
            r_ent_wr[i] <= '0;
         end
      end else if (w_accept && !w_conflict) begin
         r_ent_id[w_wr_idx] <= s_axis_tdata_owner_programID;
         r_ent_rd[w_wr_idx] <= s_axis_tdata_read_dependencies;
         r_ent_wr[w_wr_idx] <= s_axis_tdata_write_dependencies;
      end else if (w_last_beat && r_carry_valid) begin
         r_ent_id[0] <= r_carry_id;
         r_ent_rd[0] <= r_carry_rd;
         r_ent_wr[0] <= r_carry_wr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state                         <= COLLECT;
         r_count                         <= '0;
         r_rd_idx                        <= '0;
         r_timer                         <= '0;
         r_mask_r                        <= '0;
         r_mask_w                        <= '0;
         r_carry_valid                   <= 1'b0;
         r_carry_id                      <= '0;
         r_carry_rd                      <= '0;
         r_carry_wr                      <= '0;
         m_axis_tvalid                   <= 1'b0;
         m_axis_tlast                    <= 1'b0;
         m_axis_tdata_owner_programID    <= '0;
         m_axis_tdata_read_dependencies  <= '0;
         m_axis_tdata_write_dependencies <= '0;
      end else begin
         case (r_state)
            COLLECT: begin
               if (w_accept) begin
                  if (w_conflict) begin
                     r_carry_valid <= 1'b1;
                     r_carry_id    <= s_axis_tdata_owner_programID;
                     r_carry_rd    <= s_axis_tdata_read_dependencies;
                     r_carry_wr    <= s_axis_tdata_write_dependencies;
                     r_state       <= DRAIN;
                  end else begin
                     r_mask_r <= r_mask_r | s_axis_tdata_read_dependencies;
                     r_mask_w <= r_mask_w | s_axis_tdata_write_dependencies;
                     r_count  <= w_count_inc;
                     r_timer  <= '0;
                     if (w_count_inc == C_FULL) begin
                        r_state <= DRAIN;
                     end
                  end
               end else if (r_count != '0) begin
                  if (r_timer == C_TIMEOUT_LAST) begin
                     r_timer <= '0;
                     r_state <= DRAIN;
                  end else begin
                     r_timer <= r_timer + TIM_W'(1);
                  end
               end
            end
            DRAIN: begin
               // First drain cycle loads the output register from entry 0.
               if (!m_axis_tvalid) begin
                  m_axis_tvalid                   <= 1'b1;
                  m_axis_tlast                    <= (r_rd_idx == w_last_idx);
                  m_axis_tdata_owner_programID    <= r_ent_id[r_rd_idx];
                  m_axis_tdata_read_dependencies  <= r_ent_rd[r_rd_idx];
                  m_axis_tdata_write_dependencies <= r_ent_wr[r_rd_idx];
               end else if (m_axis_tready) begin
                  if (m_axis_tlast) begin
                     m_axis_tvalid <= 1'b0;
                     m_axis_tlast  <= 1'b0;
                     r_rd_idx      <= '0;
                     r_timer       <= '0;
                     r_state       <= COLLECT;
                     if (r_carry_valid) begin
                        r_mask_r      <= r_carry_rd;
                        r_mask_w      <= r_carry_wr;
                        r_count       <= CNT_W'(1);
                        r_carry_valid <= 1'b0;
                     end else begin
                        r_mask_r <= '0;
                        r_mask_w <= '0;
                        r_count  <= '0;
                     end
                  end else begin
                     r_rd_idx                        <= w_next_idx;
                     m_axis_tlast                    <= (w_next_idx == w_last_idx);
                     m_axis_tdata_owner_programID    <= r_ent_id[w_next_idx];
                     m_axis_tdata_read_dependencies  <= r_ent_rd[w_next_idx];
                     m_axis_tdata_write_dependencies <= r_ent_wr[w_next_idx];
                  end
               end
            end
         endcase
      end
   end

`ifdef BATCHER_STATS_EN
   logic [31:0] r_batch_count;
   logic [31:0] r_conflict_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_batch_count    <= '0;
         r_conflict_count <= '0;
      end else begin
         if (w_last_beat) begin
            r_batch_count <= r_batch_count + 32'd1;
         end
         if (w_accept && w_conflict) begin
            r_conflict_count <= r_conflict_count + 32'd1;
         end
      end
   end

   assign batch_count    = r_batch_count;
   assign conflict_count = r_conflict_count;
`else
   assign batch_count    = 32'd0;
   assign conflict_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_conflict_batcher.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conflict_batcher
//  Purpose  : Self-checking bench for conflict_batcher (vectors, directed
//             sequences and random traffic against a queue-based model).
//  Revision : 1.0  initial release
// ============================================================================
module tb_conflict_batcher;

   localparam int MD  = 256;
   localparam int MBS = 8;
   localparam int TMO = 64;
`ifdef BATCHER_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif

   typedef struct packed {
      logic [63:0]   id;
      logic [MD-1:0] rd;
      logic [MD-1:0] wr;
   } txn_t;

   typedef struct {
      logic [7:0] ra;
      logic [7:0] wa;
      logic [7:0] rb;
      logic [7:0] wb;
      int         first_beats;
      int         conf;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [63:0]   s_id = '0;
   logic [MD-1:0] s_rd = '0;
   logic [MD-1:0] s_wr = '0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b0;
   logic          m_axis_tlast;
   logic [63:0]   m_id;
   logic [MD-1:0] m_rd;
   logic [MD-1:0] m_wr;
   logic [31:0]   batch_count;
   logic [31:0]   conflict_count;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model: open batch as a queue, pairwise conflict test.
   txn_t mq[$];
   txn_t md_carry;
   bit   md_cv, md_drain, md_pres;
   int   md_oidx, md_idle, md_bc, md_cc, md_acc;

   logic [63:0] obs_id[$];
   bit          obs_last[$];

   conflict_batcher #(
      .MAX_DEPENDENCIES(MD),
      .MAX_BATCH_SIZE  (MBS),
      .BATCH_TIMEOUT   (TMO)
   ) dut (
      .clk                             (clk),
      .rst_n                           (rst_n),
      .s_axis_tvalid                   (s_axis_tvalid),
      .s_axis_tready                   (s_axis_tready),
      .s_axis_tdata_owner_programID    (s_id),
      .s_axis_tdata_read_dependencies  (s_rd),
      .s_axis_tdata_write_dependencies (s_wr),
      .m_axis_tvalid                   (m_axis_tvalid),
      .m_axis_tready                   (m_axis_tready),
      .m_axis_tlast                    (m_axis_tlast),
      .m_axis_tdata_owner_programID    (m_id),
      .m_axis_tdata_read_dependencies  (m_rd),
      .m_axis_tdata_write_dependencies (m_wr),
      .batch_count                     (batch_count),
      .conflict_count                  (conflict_count)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [MD-1:0] act, input logic [MD-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] exp_stat(input int v);
      return STATS ? 32'(v) : 32'd0;
   endfunction

   function automatic logic [MD-1:0] bit_at(input int n);
      logic [MD-1:0] v;
      v = '0;
      v[n] = 1'b1;
      return v;
   endfunction

   function automatic txn_t mk(input logic [63:0] id, input logic [MD-1:0] r, input logic [MD-1:0] w);
      txn_t t;
      t.id = id;
      t.rd = r;
      t.wr = w;
      return t;
   endfunction

   function automatic logic [MD-1:0] rand_set();
      if ($urandom_range(0, 3) == 0) return '0;
      if ($urandom_range(0, 15) == 0) return bit_at($urandom_range(128, 255));
      return bit_at($urandom_range(0, 11));
   endfunction

   function automatic bit md_conflicts(input txn_t t);
      foreach (mq[i]) begin
         if (((t.wr & (mq[i].rd | mq[i].wr)) != '0) || ((t.rd & mq[i].wr) != '0)) return 1'b1;
      end
      return 1'b0;
   endfunction

   task automatic model_clear();
      mq.delete();
      md_cv = 0; md_drain = 0; md_pres = 0;
      md_oidx = 0; md_idle = 0; md_bc = 0; md_cc = 0; md_acc = 0;
   endtask

   task automatic model_step(input bit iv, input txn_t t, input bit mr);
      if (!md_drain) begin
         if (iv) begin
            md_acc++;
            if (md_conflicts(t)) begin
               md_carry = t; md_cv = 1; md_cc++; md_drain = 1;
            end else begin
               mq.push_back(t);
               md_idle = 0;
               if (mq.size() == MBS) md_drain = 1;
            end
         end else if (mq.size() > 0) begin
            md_idle++;
            if (md_idle == TMO) begin
               md_idle = 0; md_drain = 1;
            end
         end
      end else if (!md_pres) begin
         md_pres = 1;
      end else if (mr) begin
         if (md_oidx == mq.size() - 1) begin
            md_bc++; md_pres = 0; md_drain = 0; md_oidx = 0; md_idle = 0;
            mq.delete();
            if (md_cv) begin
               mq.push_back(md_carry);
               md_cv = 0;
            end
         end else begin
            md_oidx++;
         end
      end
   endtask

   // One clock: drive inputs, compare DUT against model, advance both.
   task automatic step(input bit iv, input txn_t t, input bit mr);
      txn_t e;
      s_axis_tvalid = iv;
      s_id = t.id; s_rd = t.rd; s_wr = t.wr;
      m_axis_tready = mr;
      chk("s_tready", MD'(s_axis_tready), MD'(!md_drain));
      chk("m_tvalid", MD'(m_axis_tvalid), MD'(md_pres));
      if (md_pres) begin
         e = mq[md_oidx];
         chk("m_id", MD'(m_id), MD'(e.id));
         chk("m_rd", m_rd, e.rd);
         chk("m_wr", m_wr, e.wr);
         chk("m_tlast", MD'(m_axis_tlast), MD'(md_oidx == mq.size() - 1));
      end
      chk("batch_count", MD'(batch_count), MD'(exp_stat(md_bc)));
      chk("conflict_count", MD'(conflict_count), MD'(exp_stat(md_cc)));
      if (m_axis_tvalid && mr) begin
         obs_id.push_back(m_id);
         obs_last.push_back(m_axis_tlast);
      end
      model_step(iv, t, mr);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      model_clear();
      obs_id.delete();
      obs_last.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   initial begin
      vec_t vecs[8];
      txn_t z;
      logic [63:0] held;
      int first, gap;
      bit iv;

      z = '0;
      //          ra     wa     rb     wb   first conf
      vecs[0] = '{8'h00, 8'h01, 8'h00, 8'h01, 1, 1};
      vecs[1] = '{8'h00, 8'h20, 8'h20, 8'h00, 1, 1};
      vecs[2] = '{8'h04, 8'h00, 8'h00, 8'h04, 1, 1};
      vecs[3] = '{8'h80, 8'h00, 8'h80, 8'h00, 2, 0};
      vecs[4] = '{8'h00, 8'h01, 8'h04, 8'h02, 2, 0};
      vecs[5] = '{8'h00, 8'h00, 8'hff, 8'hff, 2, 0};
      vecs[6] = '{8'h08, 8'h10, 8'h10, 8'h00, 1, 1};
      vecs[7] = '{8'h40, 8'h00, 8'h40, 8'h02, 2, 0};

      do_reset();
      chk("rst_m_tvalid", MD'(m_axis_tvalid), '0);
      chk("rst_m_tlast", MD'(m_axis_tlast), '0);
      chk("rst_m_id", MD'(m_id), '0);
      chk("rst_m_rd", m_rd, '0);
      chk("rst_batch_count", MD'(batch_count), '0);
      chk("rst_s_tready", MD'(s_axis_tready), MD'(1));

      // Pairwise conflict vectors.
      for (int i = 0; i < 8; i++) begin
         do_reset();
         step(1'b1, mk(64'hA0 + 64'(i), MD'(vecs[i].ra), MD'(vecs[i].wa)), 1'b1);
         step(1'b1, mk(64'hB0 + 64'(i), MD'(vecs[i].rb), MD'(vecs[i].wb)), 1'b1);
         repeat (85) step(1'b0, z, 1'b1);
         first = -1;
         foreach (obs_last[j]) if (obs_last[j] && first < 0) first = j + 1;
         chk($sformatf("vec%0d_first_beats", i), MD'(first), MD'(vecs[i].first_beats));
         chk($sformatf("vec%0d_total_beats", i), MD'(obs_id.size()), MD'(2));
         chk($sformatf("vec%0d_conflicts", i), MD'(conflict_count), MD'(exp_stat(vecs[i].conf)));
         chk($sformatf("vec%0d_batches", i), MD'(batch_count), MD'(exp_stat(vecs[i].conf != 0 ? 2 : 1)));
      end

      // Three disjoint writers closed by timeout.
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, mk(64'(i + 1), '0, bit_at(i)), 1'b1);
      repeat (75) step(1'b0, z, 1'b1);
      chk("tmo_beats", MD'(obs_id.size()), MD'(3));
      for (int i = 0; i < 3 && i < obs_id.size(); i++) begin
         chk($sformatf("tmo_id%0d", i), MD'(obs_id[i]), MD'(i + 1));
         chk($sformatf("tmo_last%0d", i), MD'(obs_last[i]), MD'(i == 2));
      end
      chk("tmo_batch_count", MD'(batch_count), MD'(exp_stat(1)));

      // Full batch back-to-back.
      do_reset();
      for (int i = 0; i < MBS; i++) step(1'b1, mk(64'h100 + 64'(i), '0, bit_at(i)), 1'b0);
      chk("full_tready_low", MD'(s_axis_tready), '0);
      repeat (12) step(1'b0, z, 1'b1);
      chk("full_beats", MD'(obs_id.size()), MD'(MBS));
      chk("full_tready_back", MD'(s_axis_tready), MD'(1));

      // Output stalls: ready pattern 1,0,0,1.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, mk(64'h20 + 64'(i), '0, bit_at(i)), 1'b0);
      step(1'b1, mk(64'h24, '0, bit_at(0)), 1'b0);
      step(1'b0, z, 1'b0);
      step(1'b0, z, 1'b1);
      held = m_id;
      chk("stall_held_id", MD'(held), MD'(64'h21));
      step(1'b0, z, 1'b0);
      chk("stall1_id", MD'(m_id), MD'(held));
      step(1'b0, z, 1'b0);
      chk("stall2_id", MD'(m_id), MD'(held));
      repeat (80) step(1'b0, z, 1'b1);
      chk("stall_beats", MD'(obs_id.size()), MD'(5));
      for (int i = 0; i < 5 && i < obs_id.size(); i++)
         chk($sformatf("stall_id%0d", i), MD'(obs_id[i]), MD'(64'h20 + 64'(i)));

      // Reset during beat 2 of 4 with a carry pending.
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, mk(64'h30 + 64'(i), '0, bit_at(i)), 1'b0);
      step(1'b1, mk(64'h34, '0, bit_at(1)), 1'b0);
      step(1'b0, z, 1'b0);
      step(1'b0, z, 1'b1);
      chk("mid_beat2_id", MD'(m_id), MD'(64'h31));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", MD'(m_axis_tvalid), '0);
      chk("mid_rst_tlast", MD'(m_axis_tlast), '0);
      chk("mid_rst_id", MD'(m_id), '0);
      chk("mid_rst_wr", m_wr, '0);
      chk("mid_rst_conflict_count", MD'(conflict_count), '0);
      model_clear();
      obs_id.delete();
      obs_last.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      step(1'b1, mk(64'h40, '0, bit_at(0)), 1'b1);
      repeat (75) step(1'b0, z, 1'b1);
      chk("mid_after_beats", MD'(obs_id.size()), MD'(1));
      if (obs_id.size() > 0) chk("mid_after_id", MD'(obs_id[0]), MD'(64'h40));

      // Random traffic against the model.
      do_reset();
      gap = 0;
      for (int c = 0; c < 4000; c++) begin
         if (gap > 0) begin
            iv = 1'b0;
            gap--;
         end else begin
            iv = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 39) == 0) gap = $urandom_range(50, 80);
         end
         step(iv, mk({32'(c), $urandom()}, rand_set(), rand_set()), $urandom_range(0, 3) != 0);
      end
      repeat (160) step(1'b0, z, 1'b1);
      chk("rand_all_emitted", MD'(obs_id.size()), MD'(md_acc));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
